// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads instruction memory combinationally
// and hands {pc, inst, fault} entries to decode through a 2-entry buffer.
module fetch_ctrl #(
  parameter int DEPTH    = 32,
  parameter int BITS     = 32,
  parameter int RESET_PC = 0,
  localparam int AW      = $clog2(DEPTH * (BITS / 8))
) (
  input  logic            clk,
  input  logic            rst,
  output logic [AW-1:0]   imem_addr,
  input  logic [BITS-1:0] imem_data,
  input  logic            redirect_valid,
  input  logic [AW:0]     redirect_pc,
  input  logic            halt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_inst,
  output logic [AW-1:0]   out_pc,
  output logic            out_fault,
  output logic [15:0]     stall_cnt
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] FAULTED = 1'b1;

  logic [0:0]      state;
  logic [AW:0]     pc;
  logic [AW-1:0]   buf_pc    [2];
  logic [BITS-1:0] buf_inst  [2];
  logic            buf_fault [2];
  logic            rd_ptr;
  logic            wr_ptr;
  logic [1:0]      count;
  logic            fault_pc;
  logic            pop;
  logic            enq;

  // pc keeps one extra bit so running off the end of memory reads as a fault
  assign imem_addr = pc[AW-1:0];
  assign fault_pc  = pc[AW] | (pc[1:0] != 2'b00);

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign enq       = (state == RUN) & !halt & !redirect_valid & ((count != 2'd2) | pop);

  assign out_inst  = out_valid ? buf_inst[rd_ptr]  : '0;
  assign out_pc    = out_valid ? buf_pc[rd_ptr]    : '0;
  assign out_fault = out_valid ? buf_fault[rd_ptr] : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC[AW:0];
      count  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      state  <= RUN;
    end else if (redirect_valid) begin
      pc     <= redirect_pc;
      count  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      state  <= RUN;
    end else begin
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // when full with a concurrent pop, wr_ptr equals rd_ptr: the departing head slot is reused
      if (enq) begin
        buf_pc[wr_ptr] <= pc[AW-1:0];
        wr_ptr         <= ~wr_ptr;
        if (fault_pc) begin
          buf_inst[wr_ptr]  <= '0;
          buf_fault[wr_ptr] <= 1'b1;
          state             <= FAULTED;
        end else begin
          buf_inst[wr_ptr]  <= imem_data;
          buf_fault[wr_ptr] <= 1'b0;
          pc                <= pc + (AW + 1)'(4);
        end
      end
      count <= count + {1'b0, enq} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: expected entries are queued as stimulus is issued
// and checked against every handshake the consumer completes.
module tb_fetch_ctrl;

  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          redirect_valid = 1'b0;
  logic [AW:0]   redirect_pc = '0;
  logic          halt = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_inst;
  logic [AW-1:0] out_pc;
  logic          out_fault;
  logic [15:0]   stall_cnt;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [31:0]   inst;
    logic          fault;
  } ent_t;

  ent_t q[$];
  int   tests  = 0;
  int   failed = 0;

  fetch_ctrl #(.DEPTH(32), .BITS(32), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_fault(out_fault), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // word i = addi xi, x0, i  (0x00000013, 0x00100093, ...)
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] idx;
    idx = 32'(a[AW-1:2]);
    return (idx << 20) | (idx << 7) | 32'h13;
  endfunction

  always_comb imem_data = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ent_t good(input logic [AW-1:0] a);
    ent_t e;
    e.pc = a; e.inst = mem_word(a); e.fault = 1'b0;
    return e;
  endfunction

  function automatic ent_t bad(input logic [AW-1:0] a);
    ent_t e;
    e.pc = a; e.inst = '0; e.fault = 1'b1;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      chk("pop_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        ent_t e;
        e = q.pop_front();
        chk("pop_pc", 32'(out_pc), 32'(e.pc));
        chk("pop_inst", out_inst, e.inst);
        chk("pop_fault", 32'(out_fault), 32'(e.fault));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget, output int n);
    n = 0;
    while (q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int n;

    // reset state
    step(); step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_fault", 32'(out_fault), 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_pc", 32'(out_pc), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);

    // streaming at one instruction per cycle
    for (int i = 0; i < 8; i++) q.push_back(good(AW'(4 * i)));
    rst = 1'b0; out_ready = 1'b1;
    chk("first_cycle_valid", 32'(out_valid), 32'd0);
    step();
    chk("second_cycle_valid", 32'(out_valid), 32'd1);
    drain("stream", 20, n);
    chk("stream_throughput", 32'(n), 32'd8);

    // reset while the buffer is full
    out_ready = 1'b0;
    step();
    chk("full_stall", 32'(stall_cnt), 32'd1);
    rst = 1'b1;
    step();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_stall", 32'(stall_cnt), 32'd0);

    // backpressure from restart at RESET_PC
    rst = 1'b0;
    step();
    repeat (5) step();
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_head_pc", 32'(out_pc), 32'd0);
    chk("bp_stall", 32'(stall_cnt), 32'd5);
    for (int i = 0; i < 4; i++) q.push_back(good(AW'(4 * i)));
    out_ready = 1'b1;
    drain("bp", 20, n);
    chk("bp_no_gaps", 32'(n), 32'd4);
    chk("bp_stall_held", 32'(stall_cnt), 32'd5);

    // redirect with full buffer and concurrent pop: head pc 16 consumed, pc 20 discarded
    q.push_back(good(AW'(16)));
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    step();
    redirect_valid = 1'b0;
    chk("redir_pop_done", 32'(q.size()), 32'd0);
    q.delete();
    q.push_back(good(AW'(8'h40)));
    q.push_back(good(AW'(8'h44)));
    chk("redir_bubble", 32'(out_valid), 32'd0);
    step();
    chk("redir_target_valid", 32'(out_valid), 32'd1);
    chk("redir_target_pc", 32'(out_pc), 32'h40);
    drain("redir", 10, n);
    out_ready = 1'b0;
    chk("redir_stall_kept", 32'(stall_cnt), 32'd5);

    // misaligned target -> single fault entry, then stuck until redirected
    redirect_valid = 1'b1; redirect_pc = 8'h42;
    step();
    redirect_valid = 1'b0;
    q.delete();
    q.push_back(bad(AW'(8'h42)));
    step();
    chk("mis_fault", 32'(out_fault), 32'd1);
    chk("mis_inst", out_inst, 32'd0);
    chk("mis_pc", 32'(out_pc), 32'h42);
    out_ready = 1'b1;
    repeat (5) step();
    chk("mis_stuck_valid", 32'(out_valid), 32'd0);
    chk("mis_stuck_q", 32'(q.size()), 32'd0);
    q.push_back(good(AW'(8'h10)));
    q.push_back(good(AW'(8'h14)));
    redirect_valid = 1'b1; redirect_pc = 8'h10;
    step();
    redirect_valid = 1'b0;
    drain("recover", 10, n);
    out_ready = 1'b0;

    // last word, then overflow fault with truncated pc and no wrap
    q.delete();
    q.push_back(good(AW'(8'h7C)));
    q.push_back(bad(AW'(0)));
    redirect_valid = 1'b1; redirect_pc = 8'h7C;
    step();
    redirect_valid = 1'b0; out_ready = 1'b1;
    repeat (8) step();
    chk("ovf_q", 32'(q.size()), 32'd0);
    chk("ovf_no_wrap", 32'(out_valid), 32'd0);

    // halt mid-stream: no skipped or duplicated pcs
    for (int i = 0; i < 8; i++) q.push_back(good(AW'(8'h20 + 4 * i)));
    redirect_valid = 1'b1; redirect_pc = 8'h20;
    step();
    redirect_valid = 1'b0;
    step(); step();
    halt = 1'b1;
    repeat (3) step();
    chk("halt_drained_valid", 32'(out_valid), 32'd0);
    halt = 1'b0;
    drain("halt", 30, n);
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
